seq_detector_param: RTL and testbench

// - Parametrised serial-bit sequence detector; successor to the fixed-pattern detector.
// - Pattern, length (1..MAX_LEN) and overlap mode are runtime-programmable; input has a

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_det_match_cnt.sv | 35 +++
 rtl/seq_detector_param.sv | 119 +++++++++++
 tb/tb_seq_detector_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
// Provides default sizing constants, the default-width length type and the
// control FSM state encoding.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef logic [$clog2(DEF_MAX_LEN+1)-1:0] len_t;

  // DISABLED: len==0, FILLING: fill<len, ARMED: fill>=len
  typedef enum logic [1:0] {
    StDisabled,
    StFilling,
    StArmed
  } state_e;

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter.
// Ports:
//   clk   - clock, posedge
//   rst   - synchronous active-high reset
//   clr   - clear count (applied before inc in the same cycle)
//   inc   - increment by one, holds at all-ones
//   count - current count
module seq_det_match_cnt
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) count_d = '0;
    if (inc && (count_d != '1)) count_d = count_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit sequence detector.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   in, in_valid - serial data bit and its qualifier
//   cfg_load     - latch cfg_pattern/cfg_len/cfg_overlap, clear history
//   cfg_pattern  - pattern, bit [len-1] received first, bit [0] last
//   cfg_len      - pattern length, clamped to MAX_LEN; 0 disables detection
//   cfg_overlap  - 1 keeps history after a match, 0 needs len fresh bits
//   count_clr    - clear match_count (a same-cycle match still counts)
//   out          - registered one-cycle match pulse
//   match_count  - saturating match count
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in,
  input  logic                         in_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         count_clr,
  output logic                         out,
  output logic [CNT_W-1:0]             match_count
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN+1);
  localparam logic [LEN_W-1:0] MaxLenL  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   MaxFillW = (LEN_W+1)'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_sat;
  logic [LEN_W:0]     fill_inc;
  logic               overlap_q, overlap_d;
  logic               out_q;
  logic               match;
  state_e             state_q, state_d;

  // Compare window: only the low len bits of history/pattern take part.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) mask[i] = (i < 32'(len_q));
  end

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    match     = 1'b0;

    hist_n   = {hist_q[MAX_LEN-2:0], in};
    // One extra bit so fill+1 cannot wrap when MAX_LEN+1 is a power of two.
    fill_inc = {1'b0, fill_q} + 1'b1;
    fill_sat = (fill_inc > MaxFillW) ? MaxLenL : fill_inc[LEN_W-1:0];

    if (cfg_load) begin
      // Config wins over a coincident data bit, which is dropped.
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > MaxLenL) ? MaxLenL : cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = hist_n;
      fill_d = fill_sat;
      // ARMED already has enough bits; FILLING becomes full exactly when fill+1 reaches len.
      match  = (state_q != StDisabled) &&
               ((state_q == StArmed) || (fill_inc >= {1'b0, len_q})) &&
               (((hist_n ^ pattern_q) & mask) == '0);
      if (match && !overlap_q) fill_d = '0;
    end

    if (len_d == '0)          state_d = StDisabled;
    else if (fill_d >= len_d) state_d = StArmed;
    else                      state_d = StFilling;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b1;
      out_q     <= 1'b0;
      state_q   <= StDisabled;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      out_q     <= match;
      state_q   <= state_d;
    end
  end

  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (count_clr),
    .inc   (match),
    .count (match_count)
  );

  assign out = out_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
// Two instances share all inputs: a 16-bit counter one and a 2-bit counter one.
module tb_seq_detector_param;

  logic        clk = 1'b0;
  logic        rst, in, in_valid, cfg_load, cfg_overlap, count_clr;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        out_a, out_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .out(out_a), .match_count(cnt_a)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .out(out_b), .match_count(cnt_b)
  );

  typedef struct {
    logic        b;
    logic        vld;
    logic        load;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic        clr;
    logic        exp_out;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: bits eligible for a match since the last clear.
  bit       mq[$];
  int       m_len;
  bit [7:0] m_pat;
  bit       m_ovl;
  bit       m_out;
  int       m_cnt, m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic vld, input logic load, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, input logic clr, input logic r);
    in = b; in_valid = vld; cfg_load = load; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; count_clr = clr; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic b, input logic vld, input logic load, input logic [7:0] pat,
                     input logic [3:0] len, input logic ovl, input logic clr,
                     input logic eo, input logic [15:0] ec);
    vec_t v;
    v.b = b; v.vld = vld; v.load = load; v.pat = pat; v.len = len; v.ovl = ovl;
    v.clr = clr; v.exp_out = eo; v.exp_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic model_step(input bit b, input bit vld, input bit load, input bit [7:0] pat,
                            input int len, input bit ovl, input bit clr, input bit r);
    bit hit;
    hit = 1'b0;
    if (r) begin
      mq.delete(); m_len = 0; m_pat = '0; m_ovl = 1'b1;
      m_cnt = 0; m_cnt2 = 0; m_out = 1'b0;
      return;
    end
    if (load) begin
      m_pat = pat; m_len = (len > 8) ? 8 : len; m_ovl = ovl; mq.delete();
    end else if (vld) begin
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      if (m_len > 0 && mq.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (mq[mq.size()-1-k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) mq.delete();
    end
    m_out = hit;
    if (clr) begin m_cnt = 0; m_cnt2 = 0; end
    if (hit) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  // Feeds a serial bit list with in_valid=1 and no config activity.
  task automatic feed(input string name, input bit bits[$], input bit exp_o[$]);
    for (int i = 0; i < bits.size(); i++) begin
      drive(bits[i], 1, 0, 8'h00, 4'd0, 1, 0, 0);
      chk($sformatf("%s_b%0d_out", name, i), out_a, exp_o[i]);
    end
  endtask

  initial begin
    bit sb[$];
    bit se[$];
    bit r_b, r_vld, r_load, r_ovl, r_clr, r_rst;
    bit [7:0] r_pat;
    bit [3:0] r_len;
    int r;

    in = 0; in_valid = 0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; count_clr = 0; rst = 1;

    // Reset state
    drive(0, 0, 0, 8'h00, 4'd0, 0, 0, 1);
    drive(0, 0, 0, 8'h00, 4'd0, 0, 0, 1);
    chk("rst_out_a", out_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    // len==0 after reset: no detection even on a busy stream
    for (int i = 0; i < 4; i++) begin
      drive(1'(i != 1), 1, 0, 8'h00, 4'd0, 0, 0, 0);
      chk($sformatf("dis_out%0d", i), out_a, 0);
    end

    // Table: overlap, non-overlap, length clamp
    add(0, 0, 1, 8'h0B, 4, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 1, 8'h0B, 4, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 8'hA5, 15, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].b, tbl[i].vld, tbl[i].load, tbl[i].pat, tbl[i].len, tbl[i].ovl,
            tbl[i].clr, 0);
      chk($sformatf("tbl%0d_out", i), out_a, tbl[i].exp_out);
      chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].exp_cnt);
    end

    // rst mid-stream discards history and reverts config to len=0
    drive(0, 0, 1, 8'h0B, 4'd4, 1, 1, 0);
    sb = '{1, 0, 1}; se = '{0, 0, 0};
    feed("prerst", sb, se);
    drive(0, 0, 0, 8'h00, 4'd0, 0, 0, 1);
    chk("rst_mid_out", out_a, 0);
    sb = '{1, 1, 0, 1, 1}; se = '{0, 0, 0, 0, 0};
    feed("postrst", sb, se);
    chk("postrst_cnt", cnt_a, 0);

    // cfg_load with in_valid: bit dropped, fill restarts
    drive(0, 0, 1, 8'h0B, 4'd4, 1, 1, 0);
    sb = '{1, 0}; se = '{0, 0};
    feed("predrop", sb, se);
    drive(0, 1, 1, 8'h01, 4'd2, 1, 0, 0);
    chk("drop_load_out", out_a, 0);
    sb = '{1, 0, 1}; se = '{0, 0, 1};
    feed("drop", sb, se);
    chk("drop_cnt", cnt_a, 1);

    // in_valid gaps with in toggling
    drive(0, 0, 1, 8'h0B, 4'd4, 1, 1, 0);
    sb = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      drive(sb[i], 1, 0, 8'h00, 4'd0, 0, 0, 0);
      chk($sformatf("gap_b%0d_out", i), out_a, i == 3);
      for (int g = 0; g < 2; g++) begin
        drive(1'(g) ^ sb[i] ^ 1'b1, 0, 0, 8'h00, 4'd0, 0, 0, 0);
        chk($sformatf("gap_b%0d_g%0d_out", i, g), out_a, 0);
      end
    end
    chk("gap_cnt", cnt_a, 1);

    // 2-bit counter saturation, then clear coincident with a match
    drive(0, 0, 1, 8'h01, 4'd1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 8'h00, 4'd0, 0, 0, 0);
      chk($sformatf("sat%0d_out", i), out_b, 1);
      chk($sformatf("sat%0d_cnt", i), cnt_b, (i < 3) ? i + 1 : 3);
    end
    drive(1, 1, 0, 8'h00, 4'd0, 0, 1, 0);
    chk("clrhit_cnt_b", cnt_b, 1);
    chk("clrhit_cnt_a", cnt_a, 1);

    // Randomized traffic against the model
    drive(0, 0, 0, 8'h00, 4'd0, 0, 0, 1);
    model_step(0, 0, 0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      r      = $urandom_range(0, 99);
      r_rst  = (r < 2);
      r_load = (r >= 2 && r < 8) || (i == 0);
      r_clr  = (r >= 8 && r < 12);
      r_b    = 1'($urandom_range(0, 1));
      r_vld  = ($urandom_range(0, 3) != 0);
      r_pat  = 8'($urandom_range(0, 255));
      r_len  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 4));
      r_ovl  = 1'($urandom_range(0, 1));
      drive(r_b, r_vld, r_load, r_pat, r_len, r_ovl, r_clr, r_rst);
      model_step(r_b, r_vld, r_load, r_pat, int'(r_len), r_ovl, r_clr, r_rst);
      chk($sformatf("rnd%0d_out", i), out_a, m_out);
      chk($sformatf("rnd%0d_cnt_a", i), cnt_a, m_cnt);
      chk($sformatf("rnd%0d_cnt_b", i), cnt_b, m_cnt2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
